// File: rtl/sa3_conv_sequencer.sv
// -----------------------------------------------------------------------------
// sa3_conv_sequencer
//
// Drives the 3x3 systolic-array convolution engine for one job. For each
// channel it serially loads one 4x4 data tile and one 3x3 filter, runs the
// engine, and adds the 2x2 engine result into saturating accumulators. After
// the last channel it presents the (optionally ReLU'd) sums downstream.
//
// Handshakes (valid/ready): a transfer happens on the rising edge where both
// valid and ready are high. The producer holds data stable while valid is high
// and ready is low.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   start_i             one-cycle job start, honoured in IDLE only
//   num_ch_i            channels to accumulate (0 behaves as 1), taken at start
//   relu_en_i           clamp negative results to 0, taken at start
//   in_valid_i/in_data_i/in_ready_o   operand byte stream (25 bytes/channel)
//   sa_active_o         engine enable, high for the whole engine run
//   sa_a_o              data tile a11..a44, row-major, a11 at [7:0]
//   sa_b_o              filter b11..b33, row-major, b11 at [7:0]
//   sa_done_i, sa_c_i   engine done and results {c22,c21,c12,c11}
//   out_valid_o/out_data_o/out_ready_i  result {r22,r21,r12,r11}
//   busy_o              high whenever not IDLE
//   err_o               sticky engine-timeout flag, cleared by start or reset
// -----------------------------------------------------------------------------
module sa3_conv_sequencer #(
    parameter int ACC_W   = 10,
    parameter int TIMEOUT = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [3:0]         num_ch_i,
    input  logic               relu_en_i,
    input  logic               in_valid_i,
    input  logic [7:0]         in_data_i,
    output logic               in_ready_o,
    output logic               sa_active_o,
    output logic [127:0]       sa_a_o,
    output logic [71:0]        sa_b_o,
    input  logic               sa_done_i,
    input  logic [31:0]        sa_c_i,
    output logic               out_valid_o,
    output logic [4*ACC_W-1:0] out_data_o,
    input  logic               out_ready_i,
    output logic               busy_o,
    output logic               err_o
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_OUT} state_e;

    state_e               state_q;
    logic [4:0]           k_q;
    logic [4:0]           kb;
    logic [3:0]           ch_q;
    logic [3:0]           ch_last_q;
    logic                 relu_q;
    logic [WD_W-1:0]      wd_q;
    logic                 in_ready_q;
    logic                 sa_active_q;
    logic [127:0]         sa_a_q;
    logic [71:0]          sa_b_q;
    logic                 out_valid_q;
    logic [4*ACC_W-1:0]   out_data_q;
    logic                 err_q;
    logic [ACC_W-1:0]     acc_q [4];
    logic [ACC_W-1:0]     acc_d [4];
    logic signed [ACC_W:0] lane_sum [4];
    logic [4*ACC_W-1:0]   out_d;

    // Filter bytes occupy stream positions 16..24.
    assign kb = k_q - 5'd16;

    // One extra bit of headroom is enough: |acc| < 2^(ACC_W-1) and the
    // engine lane is 8-bit with ACC_W > 8.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < 4; i++) begin
            lane_sum[i] = $signed({acc_q[i][ACC_W-1], acc_q[i]})
                        + $signed({{(ACC_W-7){sa_c_i[8*i+7]}}, sa_c_i[8*i +: 8]});
            if (lane_sum[i] > SAT_MAX)
                acc_d[i] = {1'b0, {(ACC_W-1){1'b1}}};
            else if (lane_sum[i] < SAT_MIN)
                acc_d[i] = {1'b1, {(ACC_W-1){1'b0}}};
            else
                acc_d[i] = lane_sum[i][ACC_W-1:0];
            out_d[i*ACC_W +: ACC_W] = (relu_q && acc_d[i][ACC_W-1]) ? '0 : acc_d[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            ch_q        <= '0;
            ch_last_q   <= '0;
            relu_q      <= 1'b0;
            wd_q        <= '0;
            in_ready_q  <= 1'b0;
            sa_active_q <= 1'b0;
            sa_a_q      <= '0;
            sa_b_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < 4; i++) acc_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_LOAD;
                        in_ready_q <= 1'b1;
                        k_q        <= '0;
                        ch_q       <= '0;
                        ch_last_q  <= (num_ch_i == 4'd0) ? 4'd0 : num_ch_i - 4'd1;
                        relu_q     <= relu_en_i;
                        err_q      <= 1'b0;
                        for (int i = 0; i < 4; i++) acc_q[i] <= '0;
                    end
                end
                S_LOAD: begin
                    // in_ready is always high here, so in_valid alone accepts.
                    if (in_valid_i) begin
                        if (k_q < 5'd16)
                            sa_a_q[{k_q[3:0], 3'b000} +: 8] <= in_data_i;
                        else
                            sa_b_q[{kb[3:0], 3'b000} +: 8] <= in_data_i;
                        if (k_q == 5'd24) begin
                            state_q     <= S_RUN;
                            in_ready_q  <= 1'b0;
                            sa_active_q <= 1'b1;
                            wd_q        <= '0;
                        end else begin
                            k_q <= k_q + 5'd1;
                        end
                    end
                end
                S_RUN: begin
                    // sa_done has priority over the watchdog limit.
                    if (sa_done_i) begin
                        sa_active_q <= 1'b0;
                        for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
                        if (ch_q == ch_last_q) begin
                            state_q     <= S_OUT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= out_d;
                        end else begin
                            state_q    <= S_LOAD;
                            ch_q       <= ch_q + 4'd1;
                            k_q        <= '0;
                            in_ready_q <= 1'b1;
                        end
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        state_q     <= S_IDLE;
                        sa_active_q <= 1'b0;
                        err_q       <= 1'b1;
                        for (int i = 0; i < 4; i++) acc_q[i] <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign sa_active_o = sa_active_q;
    assign sa_a_o      = sa_a_q;
    assign sa_b_o      = sa_b_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q != S_IDLE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_sa3_conv_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for sa3_conv_sequencer: a simple engine model answers sa_active with
// sa_done after a chosen number of active cycles, returning per-channel result
// words chosen by each scenario. Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_sa3_conv_sequencer;
    localparam int ACC_W = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [3:0]         num_ch = 4'd0;
    logic               relu_en = 1'b0;
    logic               in_valid = 1'b0;
    logic [7:0]         in_data = 8'd0;
    logic               in_ready;
    logic               sa_active;
    logic [127:0]       sa_a;
    logic [71:0]        sa_b;
    logic               sa_done;
    logic [31:0]        sa_c;
    logic               out_valid;
    logic [4*ACC_W-1:0] out_data;
    logic               out_ready = 1'b0;
    logic               busy;
    logic               err;

    int n_vec = 0;
    int n_err = 0;

    // Engine model controls (written by the test thread only).
    int          eng_lat = 17;
    bit          eng_never = 1'b0;
    logic [31:0] eng_c [16];

    // Monitor state (written by the monitor only).
    int           act_cnt = 0;
    int           act_len = 0;
    int           eng_idx = 0;
    int           byte_cnt = 0;
    int           rdy_cnt = 0;
    int           ov_cnt = 0;
    int           unstable_cnt = 0;
    logic [127:0] a_ref = '0;
    logic [71:0]  b_ref = '0;

    sa3_conv_sequencer #(.ACC_W(ACC_W), .TIMEOUT(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .num_ch_i    (num_ch),
        .relu_en_i   (relu_en),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .sa_active_o (sa_active),
        .sa_a_o      (sa_a),
        .sa_b_o      (sa_b),
        .sa_done_i   (sa_done),
        .sa_c_i      (sa_c),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .err_o       (err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation limit reached");
        $fatal(1, "global timeout");
    end

    // ---------------- engine model and monitor ----------------
    always @(negedge clk) begin
        if (in_valid && in_ready) byte_cnt++;
        if (in_ready) rdy_cnt++;
        if (out_valid) ov_cnt++;
        if (!busy) eng_idx = 0;
        if (sa_active) begin
            act_cnt++;
            if (act_cnt == 1) begin
                a_ref = sa_a;
                b_ref = sa_b;
            end else if (sa_a !== a_ref || sa_b !== b_ref) begin
                unstable_cnt++;
            end
            if (!eng_never && act_cnt == eng_lat) begin
                sa_done = 1'b1;
                sa_c    = eng_c[eng_idx];
                eng_idx++;
            end else begin
                sa_done = 1'b0;
                sa_c    = 32'h0;
            end
        end else begin
            if (act_cnt != 0) act_len = act_cnt;
            act_cnt = 0;
            sa_done = 1'b0;
            sa_c    = 32'h0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input logic [3:0] nch, input logic relu);
        @(posedge clk); #1;
        start = 1'b1; num_ch = nch; relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL byte_accept: byte %0h not accepted within 200 cycles", d);
        end
    endtask

    // Tile a = 1..16, filter b = all ones.
    task automatic load_channel(input bit gaps);
        for (int k = 0; k < 25; k++) begin
            send_byte((k < 16) ? 8'(k + 1) : 8'd1);
            if (gaps) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(negedge clk); #1;
            if (out_valid) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL wait_out: out_valid not seen within 1000 cycles");
        end
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({in_ready, sa_active, out_valid, busy, err} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 00000", {in_ready, sa_active, out_valid, busy, err});
        end
        n_vec++;
        if (sa_a !== '0 || sa_b !== '0 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: got a=%h b=%h out=%h want 0", sa_a, sa_b, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int b0;
        logic [127:0] exp_a;
        logic [4*ACC_W-1:0] exp_o;
        for (int k = 0; k < 16; k++) exp_a[8*k +: 8] = 8'(k + 1);
        exp_o = {10'd99, 10'd90, 10'd63, 10'd54};
        eng_lat = 17; eng_never = 1'b0;
        eng_c[0] = {8'd99, 8'd90, 8'd63, 8'd54};
        b0 = byte_cnt;
        pulse_start(4'd1, 1'b0);
        load_channel(1'b0);
        wait_out(ok);
        n_vec++;
        if (out_data !== exp_o) begin
            n_err++;
            $display("FAIL single_result: got %h want %h", out_data, exp_o);
        end
        n_vec++;
        if (act_len !== 17) begin
            n_err++;
            $display("FAIL single_active_len: got %0d want 17", act_len);
        end
        n_vec++;
        if (a_ref !== exp_a || b_ref !== {9{8'h01}}) begin
            n_err++;
            $display("FAIL single_operands: got a=%h b=%h want a=%h b=%h", a_ref, b_ref, exp_a, {9{8'h01}});
        end
        n_vec++;
        if (byte_cnt - b0 !== 25) begin
            n_err++;
            $display("FAIL single_bytes: got %0d want 25", byte_cnt - b0);
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_busy_out: got %b want 1", busy);
        end
        accept_out();
        n_vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_after_hs: got valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_multi_channel();
        bit ok;
        int b0, r0;
        eng_lat = 3;
        eng_c[0] = 32'h0000000A;
        eng_c[1] = 32'h000000FB;
        eng_c[2] = 32'h00000014;
        b0 = byte_cnt; r0 = rdy_cnt;
        pulse_start(4'd3, 1'b0);
        for (int ch = 0; ch < 3; ch++) load_channel(1'b0);
        wait_out(ok);
        n_vec++;
        if (out_data !== {10'd0, 10'd0, 10'd0, 10'd25}) begin
            n_err++;
            $display("FAIL multi_result: got %h want %h", out_data, {10'd0, 10'd0, 10'd0, 10'd25});
        end
        n_vec++;
        if (byte_cnt - b0 !== 75) begin
            n_err++;
            $display("FAIL multi_bytes: got %0d want 75", byte_cnt - b0);
        end
        n_vec++;
        if (rdy_cnt - r0 !== 75) begin
            n_err++;
            $display("FAIL multi_ready_cycles: got %0d want 75", rdy_cnt - r0);
        end
        accept_out();
    endtask

    task automatic run_sat(input logic [31:0] c, input logic relu, input logic [4*ACC_W-1:0] exp_o);
        bit ok;
        eng_lat = 2;
        for (int i = 0; i < 16; i++) eng_c[i] = c;
        pulse_start(4'd15, relu);
        for (int ch = 0; ch < 15; ch++) load_channel(1'b0);
        wait_out(ok);
        n_vec++;
        if (out_data !== exp_o) begin
            n_err++;
            $display("FAIL sat_result c=%h relu=%b: got %h want %h", c, relu, out_data, exp_o);
        end
        accept_out();
    endtask

    task automatic test_saturation_relu();
        run_sat(32'h7F7F7F7F, 1'b0, {4{10'h1FF}});
        run_sat(32'h80808080, 1'b0, {4{10'h200}});
        run_sat(32'h80808080, 1'b1, {4{10'h000}});
    endtask

    task automatic test_timeout();
        int o0;
        bit idle;
        eng_never = 1'b1;
        o0 = ov_cnt;
        pulse_start(4'd1, 1'b0);
        load_channel(1'b0);
        idle = 1'b0;
        for (int n = 0; n < 100 && !idle; n++) begin
            @(negedge clk); #1;
            if (!busy) idle = 1'b1;
        end
        n_vec++;
        if (!idle) begin
            n_err++;
            $display("FAIL timeout_idle: busy still high after 100 cycles");
        end
        n_vec++;
        if (act_len !== 32) begin
            n_err++;
            $display("FAIL timeout_run_len: got %0d want 32", act_len);
        end
        n_vec++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_flags: got err=%b busy=%b want 1 0", err, busy);
        end
        n_vec++;
        if (ov_cnt - o0 !== 0) begin
            n_err++;
            $display("FAIL timeout_no_out: got %0d valid cycles want 0", ov_cnt - o0);
        end
        eng_never = 1'b0;
        pulse_start(4'd1, 1'b0);
        n_vec++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_restart: got err=%b busy=%b want 0 1", err, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int b0, u0, bad;
        logic [4*ACC_W-1:0] d0;
        eng_lat = 17;
        eng_c[0] = {8'd99, 8'd90, 8'd63, 8'd54};
        b0 = byte_cnt; u0 = unstable_cnt;
        pulse_start(4'd1, 1'b0);
        load_channel(1'b1);
        pulse_start(4'd5, 1'b1);  // during RUN: must be ignored
        wait_out(ok);
        pulse_start(4'd5, 1'b1);  // during OUT: must be ignored
        d0 = out_data;
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== d0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL bp_out_stable: got %0d unstable cycles want 0", bad);
        end
        n_vec++;
        if (d0 !== {10'd99, 10'd90, 10'd63, 10'd54}) begin
            n_err++;
            $display("FAIL bp_result: got %h want %h", d0, {10'd99, 10'd90, 10'd63, 10'd54});
        end
        n_vec++;
        if (unstable_cnt - u0 !== 0) begin
            n_err++;
            $display("FAIL bp_operands_stable: got %0d changes want 0", unstable_cnt - u0);
        end
        n_vec++;
        if (byte_cnt - b0 !== 25) begin
            n_err++;
            $display("FAIL bp_bytes: got %0d want 25", byte_cnt - b0);
        end
        accept_out();
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_after_hs: got busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_and_zero();
        bit ok;
        int o0, b0;
        eng_lat = 17;
        pulse_start(4'd1, 1'b0);
        load_channel(1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if ({in_ready, sa_active, out_valid, busy, err} !== 5'b0 ||
            sa_a !== '0 || sa_b !== '0 || out_data !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: got ctrl=%b a=%h b=%h out=%h want all 0",
                     {in_ready, sa_active, out_valid, busy, err}, sa_a, sa_b, out_data);
        end
        o0 = ov_cnt;
        repeat (30) @(negedge clk);
        n_vec++;
        if (ov_cnt - o0 !== 0) begin
            n_err++;
            $display("FAIL midrun_no_out: got %0d valid cycles want 0", ov_cnt - o0);
        end
        eng_c[0] = 32'h01020304;
        eng_c[1] = 32'h7F7F7F7F;
        b0 = byte_cnt;
        pulse_start(4'd0, 1'b0);
        load_channel(1'b0);
        wait_out(ok);
        n_vec++;
        if (out_data !== {10'd1, 10'd2, 10'd3, 10'd4}) begin
            n_err++;
            $display("FAIL zero_ch_result: got %h want %h", out_data, {10'd1, 10'd2, 10'd3, 10'd4});
        end
        n_vec++;
        if (byte_cnt - b0 !== 25) begin
            n_err++;
            $display("FAIL zero_ch_bytes: got %0d want 25", byte_cnt - b0);
        end
        accept_out();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_multi_channel();
        test_saturation_relu();
        test_timeout();
        test_backpressure();
        test_reset_and_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sa3_conv_sequencer.md
Name: sa3_conv_sequencer

Overview:
- Sequences the 3x3 systolic-array convolution engine (4x4 data tile, 3x3 filter, 2x2 result).
- Serially loads one data tile and one filter per channel, runs the engine, and accumulates the 2x2 results across channels.
- Applies optional ReLU, then presents the final 2x2 result through a valid/ready handshake.
- Sits between the operand DMA stream and the downstream output buffer.

Parameters:
- ACC_W, 10, signed accumulator/output lane width (8 < ACC_W <= 16).
- TIMEOUT, 32, maximum RUN cycles to wait for sa_done before error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle job start pulse, honoured in IDLE only.
- num_ch  in  4  number of channels to accumulate, sampled at start; 0 is treated as 1.
- relu_en  in  1  ReLU enable, sampled at start.
- in_valid  in  1  operand byte valid.
- in_data  in  8  operand byte.
- in_ready  out  1  operand byte accepted when in_valid && in_ready.
- sa_active  out  1  engine enable (active_sa3), held high for the whole engine run.
- sa_a  out  128  data tile a11..a44, row-major, a11 at [7:0].
- sa_b  out  72  filter b11..b33, row-major, b11 at [7:0].
- sa_done  in  1  engine done.
- sa_c  in  32  engine results {c22,c21,c12,c11}, c11 at [7:0], each signed 8-bit.
- out_valid  out  1  result valid.
- out_data  out  4*ACC_W  results {r22,r21,r12,r11}, r11 at [ACC_W-1:0].
- out_ready  in  1  downstream accept.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky timeout flag; cleared by start or rst.

Behaviour:
- Reset (synchronous, any state): state=IDLE; all outputs 0; operand regs, accumulators and counters cleared. A reset mid-job aborts the job without producing output.
- IDLE:
  - start=1 -> LOAD next cycle; latches num_ch and relu_en; clears accumulators, channel count and err.
  - Otherwise stay in IDLE.
- LOAD:
  - in_ready=1.
  - Each accepted byte goes to index k = 0..24: k 0-15 -> sa_a byte k; k 16-24 -> sa_b byte k-16.
  - Gaps in in_valid are allowed.
  - After the byte with k=24 is accepted -> RUN. sa_active rises on the cycle after the last byte.
- RUN:
  - sa_active=1; sa_a and sa_b held stable; watchdog increments each cycle.
  - On sa_done=1, sa_c is sampled that cycle and each lane is sign-extended and added to its accumulator, saturating to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - After the sampled sa_done: if this was the last channel -> OUT, otherwise channel+1 and -> LOAD with k=0. sa_active falls on the next cycle.
  - If the watchdog reaches TIMEOUT with no sa_done -> IDLE with err=1; accumulators are discarded and no output is produced.
- OUT:
  - out_valid=1; out_data = accumulators, with negative lanes forced to 0 when relu_en=1.
  - out_data is held stable until out_ready=1.
  - On the out_valid && out_ready cycle -> IDLE; out_valid falls on the next cycle.
- Ignored inputs: start when not IDLE; in_valid outside LOAD (in_ready=0); sa_done outside RUN; out_ready outside OUT.
- If sa_done and the watchdog limit occur in the same cycle, sa_done wins.
- Minimum per-channel latency: 25 load cycles + 1 + engine cycles + 1.

Test Plan:
- Single channel: a=1..16, b=all 1, num_ch=1, relu_en=0; bench engine model returns sa_c={99,90,63,54} with done on the 17th active cycle -> out_data lanes r11..r22 = 54,63,90,99; sa_active high exactly 17 cycles; busy falls after the handshake.
- Multi-channel accumulate: num_ch=3, model returns c11 = 10, -5, 20 across the three channels -> r11=25; in_ready is high only during the three LOAD phases; 75 bytes are consumed in total.
- Saturation and ReLU: num_ch=15, model returns all lanes 127 -> all lanes 511 (ACC_W=10). Repeat with -128, relu_en=0 -> -512. Repeat with relu_en=1 -> 0.
- Timeout: model never asserts done -> exactly 32 RUN cycles, then err=1, busy=0, out_valid never asserted. A following start clears err.
- Backpressure and gaps: in_valid toggling 1-0 during LOAD, out_ready held low for 10 cycles -> sa_a/sa_b and out_data stay stable; the result matches scenario 1. start pulses during RUN and OUT are ignored.
- Reset mid-RUN and num_ch=0: rst asserted in cycle 5 of RUN -> all outputs 0 next cycle, no out_valid. A new job with num_ch=0 runs exactly one channel.
